// File: rtl/hood_timer_ctrl.sv
// Timed-mode sequencer for the range hood: owns mode_cmd, runs the hurricane,
// menu-exit and self-clean countdowns, and reports seconds remaining.
module hood_timer_ctrl #(
    parameter int TICK_CYC = 100_000_000,
    parameter int HURR_S   = 60,
    parameter int EXIT_S   = 60,
    parameter int CLEAN_S  = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_on,
    input  logic       menu_req,
    input  logic       mode1_req,
    input  logic       mode2_req,
    input  logic       hurr_req,
    input  logic       clean_req,
    output logic [2:0] mode_cmd,
    output logic [7:0] remaining_s,
    output logic       busy,
    output logic       done,
    output logic       hurr_used
);

    localparam int              PW      = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_CYC - 1);

    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_STANDBY = 3'd1;
    localparam logic [2:0] S_MANUAL  = 3'd2;
    localparam logic [2:0] S_HURR    = 3'd3;
    localparam logic [2:0] S_EXIT    = 3'd4;
    localparam logic [2:0] S_CLEAN   = 3'd5;

    logic [2:0]    state, state_n;
    logic          lvl2, lvl2_n;
    logic [7:0]    rem_n;
    logic [PW-1:0] pre, pre_n;
    logic          done_n, used_n;
    logic          timed, tick, last;

    assign timed = (state == S_HURR) || (state == S_EXIT) || (state == S_CLEAN);
    assign tick  = timed && (pre == PRE_MAX);
    assign last  = tick && (remaining_s == 8'd1);
    assign busy  = timed;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        lvl2_n  = lvl2;
        used_n  = hurr_used;
        done_n  = 1'b0;
        pre_n   = tick ? '0 : (timed ? pre + PW'(1) : '0);
        rem_n   = (tick && remaining_s != 8'd0) ? remaining_s - 8'd1 : remaining_s;

        if (!power_on) begin
            state_n = S_OFF;
            lvl2_n  = 1'b0;
            used_n  = 1'b0;
            pre_n   = '0;
            rem_n   = 8'd0;
        end else begin
            case (state)
                S_OFF: state_n = S_STANDBY;
                S_STANDBY: begin
                    if (clean_req) begin
                        state_n = S_CLEAN;
                        rem_n   = 8'(CLEAN_S);
                        pre_n   = '0;
                    end else if (hurr_req && !hurr_used) begin
                        state_n = S_HURR;
                        rem_n   = 8'(HURR_S);
                        pre_n   = '0;
                        used_n  = 1'b1;
                    end else if (mode2_req) begin
                        state_n = S_MANUAL;
                        lvl2_n  = 1'b1;
                    end else if (mode1_req) begin
                        state_n = S_MANUAL;
                        lvl2_n  = 1'b0;
                    end
                end
                S_MANUAL: begin
                    if (menu_req) begin
                        state_n = S_STANDBY;
                    end else if (hurr_req && !hurr_used) begin
                        state_n = S_HURR;
                        rem_n   = 8'(HURR_S);
                        pre_n   = '0;
                        used_n  = 1'b1;
                    end else if (mode2_req) begin
                        lvl2_n = 1'b1;
                    end else if (mode1_req) begin
                        lvl2_n = 1'b0;
                    end
                end
                S_HURR: begin
                    // menu_req outranks a coincident expiry: no fallback, no done
                    if (menu_req) begin
                        state_n = S_EXIT;
                        rem_n   = 8'(EXIT_S);
                        pre_n   = '0;
                    end else if (last) begin
                        state_n = S_MANUAL;
                        lvl2_n  = 1'b1;
                        done_n  = 1'b1;
                    end
                end
                S_EXIT, S_CLEAN: begin
                    if (last) begin
                        state_n = S_STANDBY;
                        done_n  = 1'b1;
                    end
                end
                default: begin
                    state_n = S_OFF;
                    rem_n   = 8'd0;
                    pre_n   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_OFF;
            lvl2        <= 1'b0;
            remaining_s <= 8'd0;
            pre         <= '0;
            done        <= 1'b0;
            hurr_used   <= 1'b0;
        end else begin
            state       <= state_n;
            lvl2        <= lvl2_n;
            remaining_s <= rem_n;
            pre         <= pre_n;
            done        <= done_n;
            hurr_used   <= used_n;
        end
    end

    always_comb begin
        case (state)
            S_MANUAL:        mode_cmd = lvl2 ? 3'b010 : 3'b001;
            S_HURR, S_EXIT:  mode_cmd = 3'b011;
            S_CLEAN:         mode_cmd = 3'b100;
            default:         mode_cmd = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_hood_timer_ctrl.sv
// Bench for hood_timer_ctrl: vector table, directed corner sequences and a
// random run checked against a deadline-based reference model.
module tb_hood_timer_ctrl;

    localparam int T  = 4;
    localparam int HS = 3;
    localparam int ES = 2;
    localparam int CS = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       power_on = 1'b0;
    logic       menu_req = 1'b0, mode1_req = 1'b0, mode2_req = 1'b0;
    logic       hurr_req = 1'b0, clean_req = 1'b0;
    logic [2:0] mode_cmd;
    logic [7:0] remaining_s;
    logic       busy, done, hurr_used;

    int checks = 0;
    int errors = 0;

    hood_timer_ctrl #(.TICK_CYC(T), .HURR_S(HS), .EXIT_S(ES), .CLEAN_S(CS)) dut (
        .clk(clk), .rst(rst), .power_on(power_on), .menu_req(menu_req),
        .mode1_req(mode1_req), .mode2_req(mode2_req), .hurr_req(hurr_req),
        .clean_req(clean_req), .mode_cmd(mode_cmd), .remaining_s(remaining_s),
        .busy(busy), .done(done), .hurr_used(hurr_used)
    );

    always #5 clk = ~clk;

    // Reference model: a timed state is an entry cycle plus a length in seconds.
    typedef enum int {M_OFF, M_STBY, M_MAN, M_HURR, M_EXIT, M_CLEAN} mstate_t;
    mstate_t ms = M_OFF;
    int  mlvl = 1;
    int  entry = 0, load = 0, now = 0;
    bit  mused = 0, mdone = 0;

    function automatic bit m_timed();
        return ms == M_HURR || ms == M_EXIT || ms == M_CLEAN;
    endfunction

    function automatic void m_enter(mstate_t s, int n);
        ms = s; entry = now + 1; load = n;
    endfunction

    function automatic void m_reset();
        ms = M_OFF; mused = 0; mdone = 0; now = 0; mlvl = 1;
    endfunction

    function automatic void m_step(bit pwr, bit mn, bit m1, bit m2, bit h, bit c);
        bit expire;
        expire = m_timed() && ((now + 1 - entry) == load * T);
        mdone = 0;
        if (!pwr) begin
            ms = M_OFF; mused = 0;
        end else begin
            case (ms)
                M_OFF: ms = M_STBY;
                M_STBY:
                    if (c) m_enter(M_CLEAN, CS);
                    else if (h && !mused) begin m_enter(M_HURR, HS); mused = 1; end
                    else if (m2) begin ms = M_MAN; mlvl = 2; end
                    else if (m1) begin ms = M_MAN; mlvl = 1; end
                M_MAN:
                    if (mn) ms = M_STBY;
                    else if (h && !mused) begin m_enter(M_HURR, HS); mused = 1; end
                    else if (m2) mlvl = 2;
                    else if (m1) mlvl = 1;
                M_HURR:
                    if (mn) m_enter(M_EXIT, ES);
                    else if (expire) begin ms = M_MAN; mlvl = 2; mdone = 1; end
                default:
                    if (expire) begin ms = M_STBY; mdone = 1; end
            endcase
        end
        now++;
    endfunction

    function automatic int m_mode();
        case (ms)
            M_MAN:          return mlvl;
            M_HURR, M_EXIT: return 3;
            M_CLEAN:        return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic int m_rem();
        return m_timed() ? load - (now - entry) / T : 0;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic check_out(input string name, input int m, input int r, input int b,
                             input int d, input int u);
        check({name, ".mode"}, int'(mode_cmd), m);
        check({name, ".rem"},  int'(remaining_s), r);
        check({name, ".busy"}, int'(busy), b);
        check({name, ".done"}, int'(done), d);
        check({name, ".used"}, int'(hurr_used), u);
    endtask

    // One clock cycle: drive, clock, then compare the DUT against the model.
    task automatic step(input logic pwr, input logic mn, input logic m1, input logic m2,
                        input logic h, input logic c);
        power_on = pwr; menu_req = mn; mode1_req = m1; mode2_req = m2;
        hurr_req = h; clean_req = c;
        @(posedge clk);
        #1;
        m_step(pwr, mn, m1, m2, h, c);
        menu_req = 0; mode1_req = 0; mode2_req = 0; hurr_req = 0; clean_req = 0;
        check_out("model", m_mode(), m_rem(), int'(m_timed()), int'(mdone), int'(mused));
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic power_cycle();
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check_out("pcycle", 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic       pwr, menu, m1, m2, hurr, clean;
        logic [2:0] mode;
        logic [7:0] rem;
        logic       busy, done, used;
    } vec_t;

    vec_t vecs[15];

    initial begin
        //             pwr mn m1 m2 h  c   mode  rem  b  d  u
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 3'd0, 8'd0, 0, 0, 0};
        vecs[1]  = '{1, 1, 0, 0, 0, 0, 3'd0, 8'd0, 0, 0, 0};
        vecs[2]  = '{1, 0, 1, 0, 0, 0, 3'd1, 8'd0, 0, 0, 0};
        vecs[3]  = '{1, 0, 0, 1, 0, 0, 3'd2, 8'd0, 0, 0, 0};
        vecs[4]  = '{1, 0, 1, 1, 0, 0, 3'd2, 8'd0, 0, 0, 0};
        vecs[5]  = '{1, 0, 1, 0, 0, 0, 3'd1, 8'd0, 0, 0, 0};
        vecs[6]  = '{1, 1, 1, 0, 0, 0, 3'd0, 8'd0, 0, 0, 0};
        vecs[7]  = '{1, 0, 1, 1, 0, 0, 3'd2, 8'd0, 0, 0, 0};
        vecs[8]  = '{1, 1, 0, 0, 0, 0, 3'd0, 8'd0, 0, 0, 0};
        vecs[9]  = '{1, 0, 0, 0, 1, 1, 3'd4, 8'd5, 1, 0, 0};
        vecs[10] = '{1, 0, 1, 0, 0, 0, 3'd4, 8'd5, 1, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 3'd0, 8'd0, 0, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 1, 0, 3'd0, 8'd0, 0, 0, 0};
        vecs[13] = '{1, 0, 0, 0, 1, 0, 3'd0, 8'd0, 0, 0, 0};
        vecs[14] = '{1, 0, 0, 1, 1, 0, 3'd3, 8'd3, 1, 0, 1};

        // Reset state
        rst = 1'b1;
        #2;
        check_out("reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();

        // Vector table
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].pwr, vecs[i].menu, vecs[i].m1, vecs[i].m2, vecs[i].hurr, vecs[i].clean);
            check_out($sformatf("vec%0d", i), int'(vecs[i].mode), int'(vecs[i].rem),
                      int'(vecs[i].busy), int'(vecs[i].done), int'(vecs[i].used));
        end

        // Hurricane fallback
        power_cycle();
        step(1, 0, 0, 0, 1, 0);
        check_out("hurr_entry", 3, HS, 1, 0, 1);
        for (int k = 1; k < HS * T; k++) begin
            idle();
            check_out($sformatf("hurr_k%0d", k), 3, HS - k / T, 1, 0, 1);
        end
        idle();
        check_out("hurr_expire", 2, 0, 0, 1, 1);
        idle();
        check_out("hurr_after", 2, 0, 0, 0, 1);

        // Hurricane once per power cycle
        step(1, 0, 0, 0, 1, 0);
        check_out("hurr_reuse", 2, 0, 0, 0, 1);
        power_cycle();
        step(1, 0, 0, 0, 1, 0);
        check_out("hurr_again", 3, HS, 1, 0, 1);

        // Menu exit from hurricane
        for (int k = 1; k <= 4; k++) idle();
        step(1, 1, 0, 0, 0, 0);
        check_out("exit_entry", 3, ES, 1, 0, 1);
        for (int k = 1; k < ES * T; k++) begin
            step(1, 1, 1, 1, 1, 1);
            check_out($sformatf("exit_k%0d", k), 3, ES - k / T, 1, 0, 1);
        end
        idle();
        check_out("exit_expire", 0, 0, 0, 1, 1);

        // Menu coincident with hurricane expiry tick
        power_cycle();
        step(1, 0, 0, 0, 1, 0);
        for (int k = 1; k < HS * T; k++) idle();
        check_out("race_pre", 3, 1, 1, 0, 1);
        step(1, 1, 0, 0, 0, 0);
        check_out("race_menu", 3, ES, 1, 0, 1);

        // Self-clean with priority over hurricane
        power_cycle();
        step(1, 0, 0, 0, 1, 1);
        check_out("clean_entry", 4, CS, 1, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        check_out("clean_m1", 4, CS, 1, 0, 0);
        for (int k = 2; k < CS * T; k++) begin
            idle();
            check_out($sformatf("clean_k%0d", k), 4, CS - k / T, 1, 0, 0);
        end
        idle();
        check_out("clean_expire", 0, 0, 0, 1, 0);

        // Power drop mid-clean and on the expiry cycle
        step(1, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 3; k++) idle();
        step(0, 0, 0, 0, 0, 0);
        check_out("abort_mid", 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        for (int k = 1; k < CS * T; k++) idle();
        step(0, 0, 0, 0, 0, 0);
        check_out("abort_expiry", 0, 0, 0, 0, 0);

        // Asynchronous reset mid-hurricane
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        idle();
        idle();
        check_out("pre_rst", 3, HS, 1, 0, 1);
        rst = 1'b1;
        #1;
        check_out("rst_async", 0, 0, 0, 0, 0);
        m_reset();
        @(posedge clk);
        #1;
        check_out("rst_hold", 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(1, 0, 0, 0, 1, 0);
        check_out("rst_off_step", 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        check_out("rst_hurr", 3, HS, 1, 0, 1);

        // Random run against the reference model
        for (int i = 0; i < 3000; i++) begin
            step(logic'($urandom_range(0, 39) != 0),
                 logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 7) == 0),
                 logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 9) == 0),
                 logic'($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
